// File: rtl/axil_cfg_regfile.sv
// AXI-Lite configuration register file for the brightness/contrast/gamma pipeline.
// Host writes land in shadow registers; the datapath-facing copies reload only on
// frame_sof so a frame never mixes settings. Gamma LUT accesses pass straight through
// to an external LUT port with write-first arbitration.
module axil_cfg_regfile #(
  parameter int unsigned       LUT_DEPTH    = 256,
  parameter int unsigned       LUT_IDX_LSB  = 4,
  parameter logic [7:0]        CONTRAST_RST = 8'h10,
  parameter logic signed [8:0] BRIGHT_RST   = 9'sd0,
  localparam int unsigned      IdxW         = $clog2(LUT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     s_awaddr,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [15:0]     s_wdata,
  input  logic [1:0]      s_wstrb,
  input  logic            s_wvalid,
  output logic            s_wready,
  output logic [1:0]      s_bresp,
  output logic            s_bvalid,
  input  logic            s_bready,
  input  logic [15:0]     s_araddr,
  input  logic            s_arvalid,
  output logic            s_arready,
  output logic [15:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rvalid,
  input  logic            s_rready,
  input  logic            frame_sof,
  output logic            bright_en,
  output logic            contrast_en,
  output logic            gamma_en,
  output logic [8:0]      brightness_off,
  output logic [7:0]      contrast_gain,
  output logic            lut_we,
  output logic            lut_re,
  output logic [IdxW-1:0] lut_addr,
  output logic [7:0]      lut_wdata,
  input  logic [7:0]      lut_rdata
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {WIdle, WGotAw, WGotW, WResp} wstate_e;
  typedef enum logic [1:0] {RIdle, RLut, RResp} rstate_e;

  typedef struct packed {
    logic            legal;
    logic [3:0]      sel;
    logic [IdxW-1:0] idx;
  } dec_t;

  // One-hot region select plus index; anything outside the four codes is illegal.
  function automatic dec_t decode(input logic [15:0] a);
    dec_t d;
    d.sel   = a[3:0];
    d.idx   = a[LUT_IDX_LSB +: IdxW];
    d.legal = 1'b0;
    if (a[15:LUT_IDX_LSB+IdxW] == '0) begin
      case (a[3:0])
        4'b0001, 4'b0010, 4'b0100: d.legal = (d.idx == '0);
        4'b1000:                   d.legal = 1'b1;
        default:                   d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

  wstate_e         wstate_q;
  rstate_e         rstate_q;
  logic            awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [15:0]     awaddr_q, wdata_q, rdata_q;
  logic [1:0]      wstrb_q;
  logic            rd_pend_q, rd_live_q;
  logic [IdxW-1:0] rd_idx_q;
  logic [2:0]      en_sh_q, en_act_q;
  logic [8:0]      bright_sh_q, bright_act_q;
  logic [7:0]      contrast_sh_q, contrast_act_q;
  logic            lut_we_q, lut_re_q;
  logic [IdxW-1:0] lut_addr_q;
  logic [7:0]      lut_wdata_q;

  logic            aw_hs, w_hs, ar_hs, wr_fire;
  logic [15:0]     wr_addr, wr_data, rd_reg_data;
  logic [1:0]      wr_strb;
  dec_t            wr_dec, rd_dec;
  logic            lut_we_d, lut_re_d, rd_lut_new;
  logic            unused_wdata;

  assign aw_hs = s_awready & s_awvalid;
  assign w_hs  = s_wready & s_wvalid;
  assign ar_hs = s_arready & s_arvalid;

  // Write completes on the edge where the last of AW/W is latched.
  always_comb begin
    wr_addr = (wstate_q == WGotAw) ? awaddr_q : s_awaddr;
    wr_data = (wstate_q == WGotW) ? wdata_q : s_wdata;
    wr_strb = (wstate_q == WGotW) ? wstrb_q : s_wstrb;
    case (wstate_q)
      WIdle:   wr_fire = aw_hs & w_hs;
      WGotAw:  wr_fire = w_hs;
      WGotW:   wr_fire = aw_hs;
      default: wr_fire = 1'b0;
    endcase
    wr_dec = decode(wr_addr);
    rd_dec = decode(s_araddr);
  end

  assign unused_wdata = ^wr_data[15:9];

  // LUT strobe arbitration: a write wins, a pending read retries next cycle.
  always_comb begin
    lut_we_d   = wr_fire & wr_dec.legal & wr_dec.sel[3] & wr_strb[0];
    rd_lut_new = ar_hs & rd_dec.legal & rd_dec.sel[3];
    lut_re_d   = (rd_lut_new | ((rstate_q == RLut) & rd_pend_q)) & ~lut_we_d;
  end

  // Register read mux; reads always see the shadow copies.
  always_comb begin
    rd_reg_data = '0;
    case (rd_dec.sel)
      4'b0001: rd_reg_data = {13'b0, en_sh_q};
      4'b0010: rd_reg_data = {7'b0, bright_sh_q};
      4'b0100: rd_reg_data = {8'b0, contrast_sh_q};
      default: rd_reg_data = '0;
    endcase
  end

  // Write channel FSM: independent AW/W capture, then hold B until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= WIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (wr_fire) begin
        wstate_q  <= WResp;
        awready_q <= 1'b0;
        wready_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_dec.legal ? RespOkay : RespSlverr;
      end else begin
        case (wstate_q)
          WIdle: begin
            awready_q <= ~aw_hs;
            wready_q  <= ~w_hs;
            if (aw_hs) begin
              wstate_q <= WGotAw;
              awaddr_q <= s_awaddr;
            end else if (w_hs) begin
              wstate_q <= WGotW;
              wdata_q  <= s_wdata;
              wstrb_q  <= s_wstrb;
            end
          end
          WResp: begin
            if (s_bready) begin
              wstate_q  <= WIdle;
              bvalid_q  <= 1'b0;
              awready_q <= 1'b1;
              wready_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read channel FSM: registers answer next cycle, LUT reads go via lut_re.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q  <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_live_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      case (rstate_q)
        RIdle: begin
          arready_q <= ~ar_hs;
          if (ar_hs) begin
            if (!rd_dec.legal) begin
              rstate_q <= RResp;
              rvalid_q <= 1'b1;
              rresp_q  <= RespSlverr;
              rdata_q  <= '0;
            end else if (rd_dec.sel[3]) begin
              rstate_q  <= RLut;
              rd_idx_q  <= rd_dec.idx;
              rd_pend_q <= lut_we_d;
            end else begin
              rstate_q <= RResp;
              rvalid_q <= 1'b1;
              rresp_q  <= RespOkay;
              rdata_q  <= rd_reg_data;
            end
          end
        end
        RLut: begin
          if (rd_pend_q && !lut_we_d) rd_pend_q <= 1'b0;
          // lut_re is high this cycle, so lut_rdata is valid next cycle.
          if (lut_re_q) begin
            rstate_q  <= RResp;
            rvalid_q  <= 1'b1;
            rresp_q   <= RespOkay;
            rd_live_q <= 1'b1;
          end
        end
        RResp: begin
          if (rd_live_q) begin
            rdata_q   <= {8'h00, lut_rdata};
            rd_live_q <= 1'b0;
          end
          if (s_rready) begin
            rstate_q  <= RIdle;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate_q <= RIdle;
      endcase
    end
  end

  // LUT port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_we_q    <= 1'b0;
      lut_re_q    <= 1'b0;
      lut_addr_q  <= '0;
      lut_wdata_q <= '0;
    end else begin
      lut_we_q <= lut_we_d;
      lut_re_q <= lut_re_d;
      if (lut_we_d) begin
        lut_addr_q  <= wr_dec.idx;
        lut_wdata_q <= wr_data[7:0];
      end else if (lut_re_d) begin
        lut_addr_q <= (rstate_q == RIdle) ? rd_dec.idx : rd_idx_q;
      end
    end
  end

  // Shadow register writes with byte strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sh_q       <= '0;
      bright_sh_q   <= BRIGHT_RST;
      contrast_sh_q <= CONTRAST_RST;
    end else if (wr_fire && wr_dec.legal) begin
      unique case (1'b1)
        wr_dec.sel[0]: if (wr_strb[0]) en_sh_q <= wr_data[2:0];
        wr_dec.sel[1]: begin
          if (wr_strb[0]) bright_sh_q[7:0] <= wr_data[7:0];
          if (wr_strb[1]) bright_sh_q[8]   <= wr_data[8];
        end
        wr_dec.sel[2]: if (wr_strb[0]) contrast_sh_q <= wr_data[7:0];
        wr_dec.sel[3]: ;
      endcase
    end
  end

  // Active copies reload from shadows on start of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_act_q       <= '0;
      bright_act_q   <= BRIGHT_RST;
      contrast_act_q <= CONTRAST_RST;
    end else if (frame_sof) begin
      en_act_q       <= en_sh_q;
      bright_act_q   <= bright_sh_q;
      contrast_act_q <= contrast_sh_q;
    end
  end

  assign s_awready      = awready_q;
  assign s_wready       = wready_q;
  assign s_bvalid       = bvalid_q;
  assign s_bresp        = bresp_q;
  assign s_arready      = arready_q;
  assign s_rvalid       = rvalid_q;
  assign s_rresp        = rresp_q;
  assign s_rdata        = rd_live_q ? {8'h00, lut_rdata} : rdata_q;
  assign bright_en      = en_act_q[0];
  assign contrast_en    = en_act_q[1];
  assign gamma_en       = en_act_q[2];
  assign brightness_off = bright_act_q;
  assign contrast_gain  = contrast_act_q;
  assign lut_we         = lut_we_q;
  assign lut_re         = lut_re_q;
  assign lut_addr       = lut_addr_q;
  assign lut_wdata      = lut_wdata_q;

endmodule
